cond_flag_unit: RTL and testbench

- Sits directly downstream of the ALU in the execute stage of the basic RISC core.
- Captures the C/N/V/Z outputs of the ALU into the program status flag register when the instruction's S bit is set.
- Feeds the registered carry back to the ALU Cin input.
- Evaluates the 4-bit instruction condition field for the decode/branch logic, with same-cycle flag forwarding, stall/flush control and a condition-fail counter.

---
 rtl/cond_flag_unit.sv | 123 ++++++++++++
 tb/tb_cond_flag_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/cond_flag_unit.sv
// Program status flag register and condition evaluator sitting behind the ALU.
// Captures N/Z/C/V on S-bit instructions, forwards them to same-cycle condition checks.
module cond_flag_unit #(
    parameter int          CNT_W       = 16,
    parameter logic [3:0]  RESET_FLAGS = 4'b0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alu_c,
    input  logic             alu_n,
    input  logic             alu_v,
    input  logic             alu_z,
    input  logic [3:0]       alu_op,
    input  logic             shifter_c,
    input  logic             s_bit,
    input  logic             stall,
    input  logic             flush,
    input  logic [3:0]       cond,
    input  logic             cond_req,
    output logic             cin_out,
    output logic [3:0]       flags_out,
    output logic             cond_valid,
    output logic             cond_true,
    output logic [CNT_W-1:0] fail_count
);

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_CS = 4'b0010, COND_CC = 4'b0011,
        COND_MI = 4'b0100, COND_PL = 4'b0101, COND_VS = 4'b0110, COND_VC = 4'b0111,
        COND_HI = 4'b1000, COND_LS = 4'b1001, COND_GE = 4'b1010, COND_LT = 4'b1011,
        COND_GT = 4'b1100, COND_LE = 4'b1101, COND_AL = 4'b1110, COND_NV = 4'b1111
    } cond_e;

    // Flag vector layout is {N, Z, C, V}.
    function automatic logic eval_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        logic res;
        {n, z, cy, v} = f;
        res = 1'b0;
        case (cond_e'(c))
            COND_EQ: res = z;
            COND_NE: res = ~z;
            COND_CS: res = cy;
            COND_CC: res = ~cy;
            COND_MI: res = n;
            COND_PL: res = ~n;
            COND_VS: res = v;
            COND_VC: res = ~v;
            COND_HI: res = cy & ~z;
            COND_LS: res = ~cy | z;
            COND_GE: res = (n == v);
            COND_LT: res = (n != v);
            COND_GT: res = ~z & (n == v);
            COND_LE: res = z | (n != v);
            COND_AL: res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    // Two-stage synchroniser: reset asserts immediately, deasserts on a clock edge.
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_int_n;

    always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 2'b00;
        else        rst_sync_q <= rst_sync_d;
    end

    assign rst_int_n = rst_sync_q[1];

    logic [3:0]       flags_q, flags_d, flags_new;
    logic             cond_valid_q, cond_valid_d;
    logic             cond_true_q, cond_true_d;
    logic [CNT_W-1:0] fail_count_q, fail_count_d;
    logic             upd, accept, is_arith;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        upd       = s_bit & ~stall & ~flush;
        accept    = cond_req & ~stall & ~flush;
        is_arith  = ~alu_op[3] | (alu_op[3:1] == 3'b101);
        flags_new = is_arith ? {alu_n, alu_z, alu_c, alu_v}
                             : {alu_n, alu_z, shifter_c, flags_q[0]};
        flags_d   = upd ? flags_new : flags_q;

        cond_valid_d = cond_valid_q;
        cond_true_d  = cond_true_q;
        fail_count_d = fail_count_q;
        if (!stall) begin
            cond_valid_d = accept;
            // flags_d is the forwarded value, so ADDS followed by BEQ sees the new Z.
            if (accept) cond_true_d = eval_cond(cond, flags_d);
            if (cond_valid_q && !cond_true_q && (fail_count_q != {CNT_W{1'b1}}))
                fail_count_d = fail_count_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample together.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            flags_q      <= RESET_FLAGS;
            cond_valid_q <= 1'b0;
            cond_true_q  <= 1'b0;
            fail_count_q <= '0;
        end else begin
            flags_q      <= flags_d;
            cond_valid_q <= cond_valid_d;
            cond_true_q  <= cond_true_d;
            fail_count_q <= fail_count_d;
        end
    end

    // Carry comes from the register only, keeping ALU Cin free of combinational loops.
    assign cin_out    = flags_q[1];
    assign flags_out  = flags_q;
    assign cond_valid = cond_valid_q;
    assign cond_true  = cond_true_q;
    assign fail_count = fail_count_q;

endmodule

// File: tb/tb_cond_flag_unit.sv
// Directed bench for cond_flag_unit: flag capture, forwarding, condition table,
// stall/flush, fail counter saturation and asynchronous reset.
module tb_cond_flag_unit;

    localparam int CNT_W = 8;
    localparam int FMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             alu_c, alu_n, alu_v, alu_z;
    logic [3:0]       alu_op;
    logic             shifter_c, s_bit, stall, flush;
    logic [3:0]       cond;
    logic             cond_req;
    logic             cin_out;
    logic [3:0]       flags_out;
    logic             cond_valid, cond_true;
    logic [CNT_W-1:0] fail_count;

    int total = 0;
    int bad   = 0;

    bit exp_v = 1'b0;
    bit exp_t = 1'b0;
    int exp_fail = 0;

    cond_flag_unit #(.CNT_W(CNT_W), .RESET_FLAGS(4'b0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_c(alu_c), .alu_n(alu_n), .alu_v(alu_v), .alu_z(alu_z),
        .alu_op(alu_op), .shifter_c(shifter_c), .s_bit(s_bit),
        .stall(stall), .flush(flush), .cond(cond), .cond_req(cond_req),
        .cin_out(cin_out), .flags_out(flags_out),
        .cond_valid(cond_valid), .cond_true(cond_true), .fail_count(fail_count)
    );

    always #5 clk = ~clk;

    // {flags NZCV, cond, expected result}, each applied with s_bit set (forwarded).
    localparam int NV = 36;
    logic [8:0] vec [0:NV-1] = '{
        {4'b0110, 4'b0000, 1'b1}, {4'b0110, 4'b0001, 1'b0}, {4'b0110, 4'b0010, 1'b1},
        {4'b0110, 4'b0011, 1'b0}, {4'b0110, 4'b0100, 1'b0}, {4'b0110, 4'b0101, 1'b1},
        {4'b0110, 4'b0110, 1'b0}, {4'b0110, 4'b0111, 1'b1}, {4'b0110, 4'b1000, 1'b0},
        {4'b0110, 4'b1001, 1'b1}, {4'b0110, 4'b1010, 1'b1}, {4'b0110, 4'b1011, 1'b0},
        {4'b0110, 4'b1100, 1'b0}, {4'b0110, 4'b1101, 1'b1}, {4'b0110, 4'b1110, 1'b1},
        {4'b0110, 4'b1111, 1'b0},
        {4'b1011, 4'b1000, 1'b1}, {4'b1011, 4'b1001, 1'b0}, {4'b1011, 4'b1010, 1'b1},
        {4'b1011, 4'b1011, 1'b0}, {4'b1011, 4'b1100, 1'b1}, {4'b1011, 4'b1101, 1'b0},
        {4'b1011, 4'b0100, 1'b1}, {4'b1011, 4'b0011, 1'b0},
        {4'b1000, 4'b1010, 1'b0}, {4'b1000, 4'b1011, 1'b1}, {4'b1000, 4'b1100, 1'b0},
        {4'b1000, 4'b1101, 1'b1}, {4'b1000, 4'b1000, 1'b0}, {4'b1000, 4'b1001, 1'b1},
        {4'b1000, 4'b0111, 1'b1}, {4'b1000, 4'b0101, 1'b0},
        {4'b0001, 4'b1010, 1'b0}, {4'b0001, 4'b1011, 1'b1}, {4'b0001, 4'b0110, 1'b1},
        {4'b0001, 4'b0001, 1'b1}
    };

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advances one clock with the currently driven inputs and checks the evaluation
    // outputs; et is the hand-computed result for a request accepted this cycle.
    task automatic cycle(input string tag, input bit et);
        if (!stall && exp_v && !exp_t && exp_fail != FMAX) exp_fail++;
        if (!stall) begin
            if (flush) exp_v = 1'b0;
            else begin
                exp_v = cond_req;
                if (cond_req) exp_t = et;
            end
        end
        @(posedge clk);
        #1;
        check({tag, ".valid"}, cond_valid, exp_v);
        check({tag, ".true"},  cond_true,  exp_t);
        check({tag, ".fail"},  fail_count, exp_fail);
    endtask

    task automatic set_alu(input logic [3:0] op, input logic [3:0] nzcv, input logic sc);
        alu_op = op;
        {alu_n, alu_z, alu_c, alu_v} = nzcv;
        shifter_c = sc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        set_alu(4'b0000, 4'b0000, 1'b0);
        s_bit = 0; stall = 0; flush = 0; cond = 4'b0000; cond_req = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset.flags", flags_out, 4'b0000);
        check("reset.cin", cin_out, 1'b0);
        check("reset.valid", cond_valid, 1'b0);
        check("reset.fail", fail_count, 0);

        // Signed add overflow with VS in the same cycle, then GE on the new flags.
        set_alu(4'b0000, 4'b1001, 1'b0);
        s_bit = 1; cond = 4'b0110; cond_req = 1;
        cycle("add_vs", 1'b1);
        check("add_vs.flags", flags_out, 4'b1001);
        check("add_vs.cin", cin_out, 1'b0);
        s_bit = 0; cond = 4'b1010;
        cycle("add_ge", 1'b1);
        check("add_ge.flags", flags_out, 4'b1001);

        // Logical op: C from shifter, V held from the prior value 1.
        set_alu(4'b1100, 4'b0100, 1'b1);
        s_bit = 1; cond_req = 0;
        cycle("logic_and", 1'b0);
        check("logic_and.flags", flags_out, 4'b0111);
        check("logic_and.cin", cin_out, 1'b1);

        // Code 1001 is logical too: alu_c ignored, shifter_c = 0, V still held.
        set_alu(4'b1001, 4'b0010, 1'b0);
        cycle("logic_1001", 1'b0);
        check("logic_1001.flags", flags_out, 4'b0001);
        check("logic_1001.cin", cin_out, 1'b0);

        set_alu(4'b0000, 4'b0000, 1'b1);
        cycle("clear", 1'b0);
        check("clear.flags", flags_out, 4'b0000);

        // s_bit clear: ALU shows 1111 but EQ uses the held Z = 0.
        set_alu(4'b0000, 4'b1111, 1'b1);
        s_bit = 0; cond = 4'b0000; cond_req = 1;
        cycle("nos_eq", 1'b0);
        check("nos_eq.flags", flags_out, 4'b0000);
        cond_req = 0;
        cycle("nos_idle", 1'b0);
        check("nos_idle.fail_one", fail_count, 1);

        // ADDS then BEQ: stale Z = 0 would fail, forwarded Z = 1 passes.
        set_alu(4'b0000, 4'b0110, 1'b0);
        s_bit = 1; cond = 4'b0000; cond_req = 1;
        cycle("fwd_eq", 1'b1);
        check("fwd_eq.flags", flags_out, 4'b0110);

        for (int i = 0; i < NV; i++) begin
            set_alu((i % 2) ? 4'b1010 : 4'b0011, vec[i][8:5], 1'b0);
            s_bit = 1; cond = vec[i][4:1]; cond_req = 1;
            cycle($sformatf("tbl%0d", i), vec[i][0]);
            check($sformatf("tbl%0d.flags", i), flags_out, vec[i][8:5]);
        end

        // Stall: nothing moves despite an update and a request.
        set_alu(4'b0000, 4'b1111, 1'b1);
        s_bit = 1; cond = 4'b1111; cond_req = 1; stall = 1;
        for (int i = 0; i < 3; i++) begin
            cycle($sformatf("stall%0d", i), 1'b0);
            check($sformatf("stall%0d.flags", i), flags_out, 4'b0001);
            check($sformatf("stall%0d.cin", i), cin_out, 1'b0);
        end

        stall = 0; flush = 1;
        cycle("flush", 1'b0);
        check("flush.flags", flags_out, 4'b0001);

        stall = 1; flush = 1;
        cycle("stall_flush", 1'b0);
        check("stall_flush.flags", flags_out, 4'b0001);

        // NV always fails: drive the counter well past all-ones.
        stall = 0; flush = 0; s_bit = 0; cond = 4'b1111; cond_req = 1;
        for (int i = 0; i < FMAX + 6; i++) cycle($sformatf("nv%0d", i), 1'b0);
        cond_req = 0;
        cycle("nv_end", 1'b0);
        check("sat.fail", fail_count, FMAX);
        cycle("nv_hold", 1'b0);
        check("sat.nowrap", fail_count, FMAX);

        // Asynchronous reset mid-cycle with flags at 1111 and a pending request.
        set_alu(4'b0000, 4'b1111, 1'b1);
        s_bit = 1; cond = 4'b1110; cond_req = 1;
        cycle("all_ones", 1'b1);
        check("all_ones.flags", flags_out, 4'b1111);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst.flags", flags_out, 4'b0000);
        check("async_rst.cin", cin_out, 1'b0);
        check("async_rst.valid", cond_valid, 1'b0);
        check("async_rst.true", cond_true, 1'b0);
        check("async_rst.fail", fail_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
